// File: rtl/sdram_init_responder.sv
// sdram_init_responder
// Device-side checker for the SDRAM power-up sequence. It watches the
// command bus, enforces power-up wait -> PRECHARGE ALL -> N auto refreshes
// -> MODE REGISTER SET with their minimum spacings, and reports either a
// clean init (init_done) or the first violation (error / error_code).

module sdram_init_responder #(
  parameter int unsigned T_DELAY = 20000, // edges after reset before first command
  parameter int unsigned T_RP    = 4,     // PRECHARGE ALL -> first AUTO REFRESH
  parameter int unsigned T_RC    = 13,    // AUTO REFRESH -> AUTO REFRESH / MRS
  parameter int unsigned N_REF   = 8,     // refreshes required before MRS
  parameter int unsigned T_MRD   = 2      // NOP-only window after MRS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dram_cs_n,
  input  logic        dram_ras_n,
  input  logic        dram_cas_n,
  input  logic        dram_we_n,
  input  logic [12:0] dram_addr,
  input  logic [1:0]  dram_ba,
  output logic        init_done,
  output logic [12:0] mode_reg,
  output logic [2:0]  cas_latency,
  output logic [2:0]  burst_len,
  output logic [3:0]  ref_count,
  output logic        error,
  output logic [2:0]  error_code
);

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_WAIT_REF,
    ST_WAIT_MRD,
    ST_READY,
    ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_REF,
    CMD_MRS,
    CMD_OTHER
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_EARLY    = 3'd1,
    ERR_PALL_A10 = 3'd2,
    ERR_SEQ      = 3'd3,
    ERR_TIMING   = 3'd4,
    ERR_FEW_REF  = 3'd5,
    ERR_BAD_MODE = 3'd6
  } err_e;

  state_e      state_q, state_d;
  logic [14:0] pwr_cnt_q, pwr_cnt_d;
  logic [4:0]  gap_q, gap_d;
  logic [3:0]  ref_count_q, ref_count_d;
  logic [12:0] mode_reg_q, mode_reg_d;
  logic        init_done_q, init_done_d;
  logic        error_q, error_d;
  logic [2:0]  error_code_q, error_code_d;

  cmd_e        cmd;
  err_e        fault;
  logic        power_ok;
  logic        gap_sat;
  logic        mode_ok;
  logic [31:0] gap_ext;
  logic [31:0] ref_min;

  // Decode the sampled command lines into a command class.
  always_comb begin
    cmd = CMD_OTHER;
    if (dram_cs_n) begin
      cmd = CMD_NOP;
    end else begin
      case ({dram_ras_n, dram_cas_n, dram_we_n})
        3'b111:  cmd = CMD_NOP;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_OTHER;
      endcase
    end
  end

  // Timing qualifiers: power-up wait, command spacing and mode legality.
  always_comb begin
    power_ok = ({17'd0, pwr_cnt_q} >= T_DELAY);
    // A saturated gap means "long enough" for any minimum.
    gap_sat  = (gap_q == 5'd31);
    gap_ext  = {27'd0, gap_q};
    ref_min  = (ref_count_q == 4'd0) ? T_RP : T_RC;
    mode_ok  = (dram_ba == 2'd0)
            && (dram_addr[12:10] == 3'd0)
            && (dram_addr[8:7] == 2'd0)
            && ((dram_addr[6:4] == 3'd2) || (dram_addr[6:4] == 3'd3))
            && (dram_addr[2:0] inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7});
  end

  // Next-state and output computation for the init-sequence FSM.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ref_count_d  = ref_count_q;
    mode_reg_d   = mode_reg_q;
    init_done_d  = init_done_q;
    error_d      = error_q;
    error_code_d = error_code_q;
    fault        = ERR_NONE;

    pwr_cnt_d = (pwr_cnt_q == '1) ? pwr_cnt_q : pwr_cnt_q + 15'd1;
    // The gap restarts at 1 on a command so it reads as the spacing g when
    // the next command arrives g edges later.
    if (cmd != CMD_NOP) begin
      gap_d = 5'd1;
    end else begin
      gap_d = gap_sat ? gap_q : gap_q + 5'd1;
    end

    case (state_q)
      ST_WAIT_PWR: begin
        if (cmd != CMD_NOP) begin
          if (!power_ok) begin
            fault = ERR_EARLY;
          end else if (cmd == CMD_PRE) begin
            if (dram_addr[10]) state_d = ST_WAIT_REF;
            else               fault   = ERR_PALL_A10;
          end else begin
            fault = ERR_SEQ;
          end
        end
      end

      ST_WAIT_REF: begin
        case (cmd)
          CMD_REF: begin
            if (!gap_sat && (gap_ext < ref_min)) begin
              fault = ERR_TIMING;
            end else if (ref_count_q != 4'd15) begin
              ref_count_d = ref_count_q + 4'd1;
            end
          end
          CMD_MRS: begin
            if (!gap_sat && (gap_ext < T_RC)) begin
              fault = ERR_TIMING;
            end else if ({28'd0, ref_count_q} < N_REF) begin
              fault = ERR_FEW_REF;
            end else if (!mode_ok) begin
              fault = ERR_BAD_MODE;
            end else begin
              mode_reg_d = dram_addr;
              state_d    = ST_WAIT_MRD;
            end
          end
          CMD_PRE, CMD_OTHER: fault = ERR_SEQ;
          default: ;
        endcase
      end

      ST_WAIT_MRD: begin
        if (cmd != CMD_NOP) begin
          fault = ERR_TIMING;
        end else if (gap_sat || (gap_ext >= T_MRD)) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end

      ST_READY: ;
      ST_ERR:   ;
      default:  state_d = ST_ERR;
    endcase

    if (fault != ERR_NONE) begin
      state_d      = ST_ERR;
      error_d      = 1'b1;
      error_code_d = fault;
    end
  end

  // State and output registers; reset returns everything to power-up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_PWR;
      pwr_cnt_q    <= '0;
      gap_q        <= '0;
      ref_count_q  <= '0;
      mode_reg_q   <= '0;
      init_done_q  <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from the
      // values computed before this edge, independent of statement order.
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      gap_q        <= gap_d;
      ref_count_q  <= ref_count_d;
      mode_reg_q   <= mode_reg_d;
      init_done_q  <= init_done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign init_done   = init_done_q;
  assign mode_reg    = mode_reg_q;
  assign cas_latency = mode_reg_q[6:4];
  assign burst_len   = mode_reg_q[2:0];
  assign ref_count   = ref_count_q;
  assign error       = error_q;
  assign error_code  = error_code_q;

endmodule
